// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcodes, ALU/immediate enums, pipeline register types
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        a_sel_pc;
    logic        b_sel_imm;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        reg_write;
    logic [2:0]  funct3;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        is_load;
    logic        is_store;
    logic        reg_write;
    logic [2:0]  funct3;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        reg_write;
  } mem_wb_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_type_e t);
    case (t)
      IMM_S:   gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   gen_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   gen_imm = {i[31:12], 12'b0};
      IMM_J:   gen_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: gen_imm = {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  function automatic alu_op_e decode_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  decode_alu = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  decode_alu = ALU_SLL;
      F3_SLT:  decode_alu = ALU_SLT;
      F3_SLTU: decode_alu = ALU_SLTU;
      F3_XOR:  decode_alu = ALU_XOR;
      F3_SR:   decode_alu = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   decode_alu = ALU_OR;
      default: decode_alu = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/pipelined_processor_alu.sv
// rtl/pipelined_processor_alu.sv - RV32I integer ALU
module alu
  import riscv_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << b[4:0];
      ALU_SLT:    y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:   y = {31'b0, a < b};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> b[4:0];
      ALU_SRA:    y = $signed(a) >>> b[4:0];
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_processor.sv
// rtl/pipelined_processor.sv - five-stage in-order RV32I core with private memories
module pipelined_processor
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 64
) (
  input logic                      clk,
  input logic                      reset,
  input logic [WIDTH-1:0]          instr_in,
  input logic [$clog2(SIZE)+1:0]   instr_wr_addr,
  input logic                      instr_wr_en
);

  localparam int LOGSIZE = $clog2(SIZE);

  logic [31:0] imem [0:SIZE-1];
  logic [31:0] dmem [0:SIZE-1];
  logic [31:0] rf [0:31];
  logic [31:0] pc;

  if_id_t  if_id;
  id_ex_t  id_ex, id_next;
  ex_mem_t ex_mem, ex_next;
  mem_wb_t mem_wb, wb_next;

  logic [31:0] fetch_instr;
  assign fetch_instr = imem[pc[LOGSIZE+1:2]];

  always_ff @(posedge clk) begin
    if (instr_wr_en) imem[instr_wr_addr[LOGSIZE+1:2]] <= instr_in;
  end

  logic [31:0] instr_d;
  logic [6:0]  opc;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [2:0]  f3_d;
  logic        alt_d;
  logic [31:0] rs1_val, rs2_val;

  assign instr_d = if_id.instr;
  assign opc     = instr_d[6:0];
  assign rd_d    = instr_d[11:7];
  assign f3_d    = instr_d[14:12];
  assign rs1_d   = instr_d[19:15];
  assign rs2_d   = instr_d[24:20];
  assign alt_d   = (instr_d[31:25] == F7_ALT);

  // A WB write to the register being read in the same cycle is passed straight through
  always_comb begin
    rs1_val = rf[rs1_d];
    rs2_val = rf[rs2_d];
    if (mem_wb.reg_write && mem_wb.rd == rs1_d) rs1_val = mem_wb.wb_data;
    if (mem_wb.reg_write && mem_wb.rd == rs2_d) rs2_val = mem_wb.wb_data;
    if (rs1_d == 5'd0) rs1_val = '0;
    if (rs2_d == 5'd0) rs2_val = '0;
  end

  always_comb begin
    id_next        = '0;
    id_next.pc     = if_id.pc;
    id_next.rs1    = rs1_d;
    id_next.rs2    = rs2_d;
    id_next.rd     = rd_d;
    id_next.op1    = rs1_val;
    id_next.op2    = rs2_val;
    id_next.funct3 = f3_d;
    id_next.imm    = gen_imm(instr_d, IMM_I);
    if (if_id.valid) begin
      id_next.valid = 1'b1;
      case (opc)
        OP_LUI: begin
          id_next.imm       = gen_imm(instr_d, IMM_U);
          id_next.alu_op    = ALU_PASS_B;
          id_next.b_sel_imm = 1'b1;
          id_next.reg_write = 1'b1;
        end
        OP_AUIPC: begin
          id_next.imm       = gen_imm(instr_d, IMM_U);
          id_next.a_sel_pc  = 1'b1;
          id_next.b_sel_imm = 1'b1;
          id_next.reg_write = 1'b1;
        end
        OP_JAL: begin
          id_next.imm       = gen_imm(instr_d, IMM_J);
          id_next.is_jal    = 1'b1;
          id_next.reg_write = 1'b1;
        end
        OP_JALR: begin
          id_next.is_jalr   = 1'b1;
          id_next.reg_write = 1'b1;
        end
        OP_BRANCH: begin
          id_next.imm       = gen_imm(instr_d, IMM_B);
          id_next.is_branch = 1'b1;
        end
        OP_LOAD: begin
          id_next.b_sel_imm = 1'b1;
          id_next.is_load   = 1'b1;
          id_next.reg_write = 1'b1;
        end
        OP_STORE: begin
          id_next.imm       = gen_imm(instr_d, IMM_S);
          id_next.b_sel_imm = 1'b1;
          id_next.is_store  = 1'b1;
        end
        OP_IMM: begin
          id_next.alu_op    = decode_alu(f3_d, alt_d && f3_d == F3_SR);
          id_next.b_sel_imm = 1'b1;
          id_next.reg_write = 1'b1;
        end
        OP_OP: begin
          id_next.alu_op    = decode_alu(f3_d, alt_d);
          id_next.reg_write = 1'b1;
        end
        default: ;
      endcase
      // rd==0 never writes, which also keeps x0 out of every forwarding match
      if (rd_d == 5'd0) id_next.reg_write = 1'b0;
    end
  end

  logic load_use;
  assign load_use = if_id.valid && id_ex.valid && id_ex.is_load && id_ex.reg_write &&
                    (id_ex.rd == rs1_d || id_ex.rd == rs2_d);

  logic [31:0] fwd_a, fwd_b, alu_a, alu_b, alu_y, target;
  logic        cond, taken;

  always_comb begin
    fwd_a = id_ex.op1;
    fwd_b = id_ex.op2;
    if (ex_mem.reg_write && ex_mem.rd == id_ex.rs1) fwd_a = ex_mem.result;
    else if (mem_wb.reg_write && mem_wb.rd == id_ex.rs1) fwd_a = mem_wb.wb_data;
    if (ex_mem.reg_write && ex_mem.rd == id_ex.rs2) fwd_b = ex_mem.result;
    else if (mem_wb.reg_write && mem_wb.rd == id_ex.rs2) fwd_b = mem_wb.wb_data;
  end

  assign alu_a = id_ex.a_sel_pc ? id_ex.pc : fwd_a;
  assign alu_b = id_ex.b_sel_imm ? id_ex.imm : fwd_b;

  alu u_alu (
    .op (id_ex.alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_comb begin
    case (id_ex.funct3)
      F3_BEQ:  cond = (fwd_a == fwd_b);
      F3_BNE:  cond = (fwd_a != fwd_b);
      F3_BLT:  cond = ($signed(fwd_a) < $signed(fwd_b));
      F3_BGE:  cond = ($signed(fwd_a) >= $signed(fwd_b));
      F3_BLTU: cond = (fwd_a < fwd_b);
      F3_BGEU: cond = (fwd_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

  assign taken  = id_ex.is_jal || id_ex.is_jalr || (id_ex.is_branch && cond);
  assign target = id_ex.is_jalr ? ((fwd_a + id_ex.imm) & ~32'd1) : (id_ex.pc + id_ex.imm);

  always_comb begin
    ex_next            = '0;
    ex_next.result     = (id_ex.is_jal || id_ex.is_jalr) ? id_ex.pc + 32'd4 : alu_y;
    ex_next.store_data = fwd_b;
    ex_next.rd         = id_ex.rd;
    ex_next.is_load    = id_ex.is_load;
    ex_next.is_store   = id_ex.is_store;
    ex_next.reg_write  = id_ex.reg_write;
    ex_next.funct3     = id_ex.funct3;
  end

  logic [LOGSIZE-1:0] mem_idx;
  logic [1:0]         lane;
  logic [31:0]        mem_word, mem_shifted, load_val, st_data;
  logic [3:0]         st_mask;

  assign mem_idx     = ex_mem.result[LOGSIZE+1:2];
  assign lane        = ex_mem.result[1:0];
  assign mem_word    = dmem[mem_idx];
  assign mem_shifted = mem_word >> {lane, 3'b000};

  always_comb begin
    case (ex_mem.funct3)
      F3_B:    load_val = {{24{mem_shifted[7]}}, mem_shifted[7:0]};
      F3_H:    load_val = {{16{mem_shifted[15]}}, mem_shifted[15:0]};
      F3_BU:   load_val = {24'b0, mem_shifted[7:0]};
      F3_HU:   load_val = {16'b0, mem_shifted[15:0]};
      default: load_val = mem_word;
    endcase
  end

  always_comb begin
    case (ex_mem.funct3)
      F3_B: begin
        st_mask = 4'b0001 << lane;
        st_data = ex_mem.store_data << {lane, 3'b000};
      end
      F3_H: begin
        st_mask = 4'b0011 << lane;
        st_data = ex_mem.store_data << {lane, 3'b000};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = ex_mem.store_data;
      end
    endcase
  end

  always_comb begin
    wb_next           = '0;
    wb_next.wb_data   = ex_mem.is_load ? load_val : ex_mem.result;
    wb_next.rd        = ex_mem.rd;
    wb_next.reg_write = ex_mem.reg_write;
  end

  logic unused_bits;
  assign unused_bits = ^{instr_wr_addr[1:0], mem_shifted[31:16]};

  // A taken jump in EX outranks everything; otherwise a load-use stall freezes PC and IF/ID
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc     <= '0;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else if (!instr_wr_en) begin
      ex_mem <= ex_next;
      mem_wb <= wb_next;
      if (taken) begin
        pc    <= target;
        if_id <= '0;
        id_ex <= '0;
      end else if (load_use) begin
        id_ex <= '0;
      end else begin
        pc    <= pc + 32'd4;
        if_id <= '{valid: 1'b1, pc: pc, instr: fetch_instr};
        id_ex <= id_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (!instr_wr_en && mem_wb.reg_write) begin
      rf[mem_wb.rd] <= mem_wb.wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !instr_wr_en && ex_mem.is_store) begin
      for (int i = 0; i < 4; i++)
        if (st_mask[i]) dmem[mem_idx][8*i +: 8] <= st_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_pipelined_processor.sv
// tb/tb_pipelined_processor.sv - directed programs checked against hand-computed state
module tb_pipelined_processor;

  localparam int SIZE = 64;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] HALT = 32'h0000006f;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic [7:0]  instr_wr_addr;
  logic        instr_wr_en;

  int tests = 0;
  int fails = 0;
  logic [31:0] prog [0:SIZE-1];

  pipelined_processor #(.WIDTH(32), .SIZE(SIZE)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_in      (instr_in),
    .instr_wr_addr (instr_wr_addr),
    .instr_wr_en   (instr_wr_en)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return i_type(imm, rs1, 3'd0, rd, 7'b0010011);
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < SIZE; i++) prog[i] = NOP;
  endtask

  task automatic load_and_run(input int cycles);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      instr_wr_en   = 1'b1;
      instr_wr_addr = 8'(i * 4);
      instr_in      = prog[i];
      @(negedge clk);
    end
    instr_wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if (dut.pc !== 32'd0) begin
      fails++;
      $display("FAIL reset_pc: got %h expected %h", dut.pc, 32'd0);
    end
    for (int r = 0; r < 32; r++) begin
      tests++;
      if (dut.rf[r] !== 32'd0) begin
        fails++;
        $display("FAIL reset_x%0d: got %h expected %h", r, dut.rf[r], 32'd0);
      end
    end
  endtask

  task automatic test_forwarding();
    int          idx [3] = '{1, 2, 3};
    logic [31:0] exp [3] = '{32'd5, 32'd8, 32'd13};
    clear_prog();
    prog[0] = addi(1, 0, 12'd5);
    prog[1] = addi(2, 1, 12'd3);
    prog[2] = r_type(7'd0, 2, 1, 3'd0, 3);
    prog[3] = HALT;
    load_and_run(20);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (dut.rf[idx[k]] !== exp[k]) begin
        fails++;
        $display("FAIL fwd_x%0d: got %h expected %h", idx[k], dut.rf[idx[k]], exp[k]);
      end
    end
  endtask

  task automatic test_load_use();
    int          idx [3] = '{4, 5, 8};
    logic [31:0] exp [3] = '{32'd13, 32'd14, 32'd27};
    clear_prog();
    prog[0] = addi(3, 0, 12'd13);
    prog[1] = s_type(12'd0, 3, 0, 3'd2);
    prog[2] = i_type(12'd0, 0, 3'd2, 4, 7'b0000011);
    prog[3] = addi(5, 4, 12'd1);
    prog[4] = r_type(7'd0, 5, 4, 3'd0, 8);
    prog[5] = HALT;
    load_and_run(25);
    tests++;
    if (dut.dmem[0] !== 32'd13) begin
      fails++;
      $display("FAIL loaduse_dmem0: got %h expected %h", dut.dmem[0], 32'd13);
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (dut.rf[idx[k]] !== exp[k]) begin
        fails++;
        $display("FAIL loaduse_x%0d: got %h expected %h", idx[k], dut.rf[idx[k]], exp[k]);
      end
    end
  endtask

  task automatic test_branch_jump();
    int          idx [8] = '{6, 9, 7, 10, 11, 12, 13, 14};
    logic [31:0] exp [8] = '{32'd0, 32'd2, 32'd16, 32'd0, 32'd4, 32'd5, 32'd36, 32'd0};
    clear_prog();
    prog[0]  = b_type(13'd8, 0, 0, 3'd0);
    prog[1]  = addi(6, 0, 12'd1);
    prog[2]  = addi(9, 0, 12'd2);
    prog[3]  = j_type(21'd8, 7);
    prog[4]  = addi(10, 0, 12'd3);
    prog[5]  = addi(11, 0, 12'd4);
    prog[6]  = b_type(13'd8, 0, 0, 3'd1);
    prog[7]  = addi(12, 0, 12'd5);
    prog[8]  = i_type(12'd41, 0, 3'd0, 13, 7'b1100111);
    prog[9]  = addi(14, 0, 12'd6);
    prog[10] = HALT;
    load_and_run(40);
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (dut.rf[idx[k]] !== exp[k]) begin
        fails++;
        $display("FAIL branch_x%0d: got %h expected %h", idx[k], dut.rf[idx[k]], exp[k]);
      end
    end
  endtask

  task automatic test_alu();
    int          idx [14] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 16, 1};
    logic [31:0] exp [14] = '{32'd11, 32'd1, 32'd0, 32'hFFFFFFFF, 32'h1FFFFFFF, 32'd24,
                              32'hFFFFFFFB, 32'hFFFFFFFB, 32'd0, 32'd1, 32'd1,
                              32'hFFFFFFFC, 32'h0000103C, 32'hFFFFFFF8};
    clear_prog();
    prog[0]  = addi(1, 0, 12'hFF8);
    prog[1]  = addi(2, 0, 12'd3);
    prog[2]  = addi(15, 0, 12'd35);
    prog[3]  = r_type(7'h20, 1, 2, 3'd0, 3);
    prog[4]  = r_type(7'h00, 2, 1, 3'd2, 4);
    prog[5]  = r_type(7'h00, 2, 1, 3'd3, 5);
    prog[6]  = r_type(7'h20, 15, 1, 3'd5, 6);
    prog[7]  = r_type(7'h00, 2, 1, 3'd5, 7);
    prog[8]  = r_type(7'h00, 15, 2, 3'd1, 8);
    prog[9]  = r_type(7'h00, 2, 1, 3'd4, 9);
    prog[10] = r_type(7'h00, 2, 1, 3'd6, 10);
    prog[11] = r_type(7'h00, 2, 1, 3'd7, 11);
    prog[12] = i_type(12'hFF9, 1, 3'd2, 12, 7'b0010011);
    prog[13] = i_type(12'hFFF, 2, 3'd3, 13, 7'b0010011);
    prog[14] = i_type(12'h401, 1, 3'd5, 14, 7'b0010011);
    prog[15] = u_type(20'd1, 16, 7'b0010111);
    prog[16] = HALT;
    load_and_run(40);
    for (int k = 0; k < 14; k++) begin
      tests++;
      if (dut.rf[idx[k]] !== exp[k]) begin
        fails++;
        $display("FAIL alu_x%0d: got %h expected %h", idx[k], dut.rf[idx[k]], exp[k]);
      end
    end
  endtask

  task automatic fib_prog(input logic [11:0] st_off);
    clear_prog();
    prog[0] = addi(1, 0, 12'd0);
    prog[1] = addi(2, 0, 12'd1);
    prog[2] = addi(3, 0, 12'd10);
    prog[3] = r_type(7'd0, 2, 1, 3'd0, 4);
    prog[4] = addi(1, 2, 12'd0);
    prog[5] = addi(2, 4, 12'd0);
    prog[6] = addi(3, 3, 12'hFFF);
    prog[7] = b_type(13'h1FF0, 0, 3, 3'd1);
    prog[8] = s_type(st_off, 1, 0, 3'd2);
    prog[9] = HALT;
  endtask

  task automatic test_fibonacci();
    int          idx [4] = '{1, 2, 3, 4};
    logic [31:0] exp [4] = '{32'd55, 32'd89, 32'd0, 32'd89};
    fib_prog(12'd4);
    load_and_run(1024);
    tests++;
    if (dut.dmem[1] !== 32'd55) begin
      fails++;
      $display("FAIL fib_dmem1: got %h expected %h", dut.dmem[1], 32'd55);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (dut.rf[idx[k]] !== exp[k]) begin
        fails++;
        $display("FAIL fib_x%0d: got %h expected %h", idx[k], dut.rf[idx[k]], exp[k]);
      end
    end
  endtask

  task automatic test_byte_access();
    int          idx [3] = '{3, 4, 5};
    logic [31:0] exp [3] = '{32'hFFFFFFFF, 32'h000000FF, 32'h000012FF};
    clear_prog();
    prog[0] = u_type(20'h12345, 1, 7'b0110111);
    prog[1] = addi(1, 1, 12'h678);
    prog[2] = s_type(12'd0, 1, 0, 3'd2);
    prog[3] = addi(2, 0, 12'hFFF);
    prog[4] = s_type(12'd2, 2, 0, 3'd0);
    prog[5] = i_type(12'd2, 0, 3'd0, 3, 7'b0000011);
    prog[6] = i_type(12'd2, 0, 3'd4, 4, 7'b0000011);
    prog[7] = i_type(12'd2, 0, 3'd1, 5, 7'b0000011);
    prog[8] = HALT;
    load_and_run(30);
    tests++;
    if (dut.dmem[0] !== 32'h12FF5678) begin
      fails++;
      $display("FAIL byte_dmem0: got %h expected %h", dut.dmem[0], 32'h12FF5678);
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (dut.rf[idx[k]] !== exp[k]) begin
        fails++;
        $display("FAIL byte_x%0d: got %h expected %h", idx[k], dut.rf[idx[k]], exp[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    fib_prog(12'd8);
    load_and_run(40);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (dut.pc !== 32'd0) begin
      fails++;
      $display("FAIL midreset_pc: got %h expected %h", dut.pc, 32'd0);
    end
    for (int r = 0; r < 32; r++) begin
      tests++;
      if (dut.rf[r] !== 32'd0) begin
        fails++;
        $display("FAIL midreset_x%0d: got %h expected %h", r, dut.rf[r], 32'd0);
      end
    end
    for (int w = 0; w < 10; w++) begin
      tests++;
      if (dut.imem[w] !== prog[w]) begin
        fails++;
        $display("FAIL midreset_imem%0d: got %h expected %h", w, dut.imem[w], prog[w]);
      end
    end
    reset = 1'b1;
    repeat (1024) @(negedge clk);
    tests++;
    if (dut.dmem[2] !== 32'd55) begin
      fails++;
      $display("FAIL midreset_dmem2: got %h expected %h", dut.dmem[2], 32'd55);
    end
    tests++;
    if (dut.rf[2] !== 32'd89) begin
      fails++;
      $display("FAIL midreset_x2: got %h expected %h", dut.rf[2], 32'd89);
    end
  endtask

  initial begin
    reset         = 1'b0;
    instr_wr_en   = 1'b0;
    instr_in      = '0;
    instr_wr_addr = '0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_jump();
    test_alu();
    test_fibonacci();
    test_byte_access();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_processor.md
Name: pipelined_processor

Overview:
- Five-stage in-order RV32I integer core: IF, ID, EX, MEM, WB.
- Contains its own word-addressed instruction memory, data memory and register file.
- Instruction memory is loaded through a testbench write port; the core then runs from PC 0.
- Top-level compute block of the design; it has no architectural outputs, so verification reads internal state hierarchically.

Parameters:
- WIDTH, 32: datapath/register width; only 32 is supported.
- SIZE, 64: depth in words of both instruction and data memory; power of two.
- LOGSIZE (localparam), $clog2(SIZE): word-index width.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-low reset.
- instr_in  input  WIDTH  instruction word to write.
- instr_wr_addr  input  LOGSIZE+2  byte address of the write; bits [1:0] ignored.
- instr_wr_en  input  1  instruction memory write enable.

Behaviour:
- Reset is sampled at posedge clk when reset==0. It clears:
  - PC to 0;
  - all pipeline registers to bubbles (NOP, no write-back);
  - register file x0..x31 to 0.
- Reset does not alter instruction or data memory contents.
- Reset mid-operation discards all in-flight instructions; none retire in that cycle.
- Instruction memory write:
  - at posedge, when instr_wr_en==1, imem[instr_wr_addr[LOGSIZE+1:2]] <= instr_in;
  - writes are accepted regardless of reset;
  - while instr_wr_en==1, PC and all pipeline registers hold (core frozen).
- Fetch:
  - imem read is combinational, indexed by PC[LOGSIZE+1:2];
  - the PC wraps modulo SIZE words.
- ISA coverage: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP ALU ops.
- Unsupported opcodes (FENCE, SYSTEM, other) execute as NOP.
- x0 always reads 0; writes to x0 are dropped.
- Register file writes at posedge in WB.
- Same-cycle WB write and ID read of the same register returns the new value (write-through bypass).
- Forwarding into the EX operands, priority EX/MEM over MEM/WB:
  - from EX/MEM ALU result;
  - from MEM/WB write-back value.
- Load-use hazard: when the instruction in EX is a load whose rd matches an rs of the instruction in ID (rd!=0):
  - PC and IF/ID hold for 1 cycle;
  - a bubble is inserted into ID/EX.
- Branches and jumps resolve in EX; predict not-taken.
  - On taken branch/JAL/JALR: the PC is loaded with the target next cycle, and IF/ID and ID/EX are flushed to bubbles (2-cycle penalty).
  - JALR target = (rs1+imm) & ~1.
- Data memory:
  - SIZE words, byte-addressable, little-endian, word index = addr[LOGSIZE+1:2];
  - synchronous write with byte/half lanes selected by addr[1:0];
  - combinational read, sign- or zero-extended per funct3.
- Misaligned accesses use the low address bits as lane select without a trap; out-of-range addresses wrap.
- Arithmetic:
  - wrap-around 32-bit;
  - shifts use the low 5 bits of the shift operand;
  - SLT is signed, SLTU is unsigned.
- Throughput is 1 instruction/cycle absent hazards; first retirement is 5 cycles after the release of reset/instr_wr_en.
- Hierarchical observation names, fixed for the verification engineer:
  - register file array rf[0:31];
  - data memory array dmem[0:SIZE-1];
  - program counter pc.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants;
  - funct3/funct7 constants;
  - ALU-op enum;
  - immediate-type enum;
  - pipeline register structs (if_id_t, id_ex_t, ex_mem_t, mem_wb_t).
- Sub-module alu: op enum and two operands in, result out. The rest stays in pipelined_processor.

Test Plan:
- Load "ADDI x1,x0,5; ADDI x2,x1,3; ADD x3,x1,x2", release -> x1=5, x2=8, x3=13; checks back-to-back forwarding.
- SW x3,0(x0); LW x4,0(x0); ADDI x5,x4,1 -> dmem[0]=13, x4=13, x5=14; checks the load-use stall.
- BEQ x0,x0,+8 with ADDI x6,x0,1 at the fall-through -> x6 stays 0, so the flush works. Then check JAL x7,+8 at PC p gives x7=p+4.
- Fibonacci program (loop computing F(10), storing it to dmem[1]), 1024 cycles -> dmem[1]=55, with correct intermediate register values.
- SB 0xFF to byte address 2, then LB and LBU from it -> 0xFFFFFFFF and 0x000000FF; dmem[0] bits [23:16]=0xFF, other bytes unchanged.
- Assert reset (0) mid-loop, then deassert -> pc=0, all rf=0, imem intact; the program reruns to the same result.
